cv32e40p_instr_obi_arbiter: RTL
===============================

Name: cv32e40p_instr_obi_arbiter

Overview:
- Shares the single OBI instruction port between two requesters: the IF-stage prefetch path (port 0, fetch) and an auxiliary requester (port 1, debug program-buffer reads or memory scrubbing).
- Sits between the prefetch buffer / aux master and the PMP / instruction-memory interface.
- Tracks outstanding transactions in order and routes each response back to the requester that issued it.
- Uses fixed priority with a starvation guard, and holds address/selection stable while a request waits for grant.

Parameters:
- DEPTH, 2: maximum outstanding (granted, not yet responded) transactions; must be ≥ 1.
- MAX_STARVE, 4: consecutive port-0 grants allowed while port 1 is requesting before port 1 is forced to win; must be ≥ 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_req_i  in  1  fetch request
- m0_addr_i  in  32  fetch address
- m0_gnt_o  out  1  fetch grant
- m0_rvalid_o  out  1  fetch response valid
- m0_rdata_o  out  32  fetch response data
- m0_err_o  out  1  fetch response error
- m1_req_i  in  1  aux request
- m1_addr_i  in  32  aux address
- m1_gnt_o  out  1  aux grant
- m1_rvalid_o  out  1  aux response valid
- m1_rdata_o  out  32  aux response data
- m1_err_o  out  1  aux response error
- instr_req_o  out  1  bus request
- instr_addr_o  out  32  bus address
- instr_gnt_i  in  1  bus grant
- instr_rvalid_i  in  1  bus response valid
- instr_rdata_i  in  32  bus response data
- instr_err_i  in  1  bus response error
- busy_o  out  1  outstanding count ≠ 0 or instr_req_o high

Behaviour:
- Clocking/reset: one clock, clk; reset is asynchronous, active-low, on rst_n.
- Reset state:
  - ID FIFO empty, outstanding count 0.
  - Starvation counter 0.
  - Lock cleared, lock_sel 0.
  - All outputs 0 (combinational outputs evaluate to 0 given an empty FIFO and no requests).
- Selection (sel), when unlocked:
  - Port 1 if m1_req_i and (!m0_req_i or starve_cnt == MAX_STARVE).
  - Otherwise port 0 if m0_req_i.
  - Otherwise sel holds at 0.
- Lock:
  - Set on any cycle with instr_req_o=1 and instr_gnt_i=0; lock_sel records sel.
  - While locked, sel = lock_sel regardless of other requests.
  - Cleared on the cycle the grant occurs.
  - OBI stability: an ungranted request keeps its address and master until granted.
- Issue:
  - instr_req_o = req of sel AND (count < DEPTH OR instr_rvalid_i).
  - A same-cycle pop frees a slot.
  - instr_addr_o = address of sel.
- Grant:
  - mX_gnt_o = instr_req_o & instr_gnt_i & (sel == X). The grant is combinational, zero latency.
  - On grant, sel is pushed into the ID FIFO.
- Response:
  - On instr_rvalid_i, the FIFO head is popped.
  - m{head}_rvalid_o = 1 and m{head}_err_o = instr_err_i.
  - rdata is broadcast to both mX_rdata_o; rvalid and err are gated per port.
  - Responses return in issue order.
- Simultaneous push and pop: count unchanged; FIFO wrap-around is modulo DEPTH pointers.
- Response with empty FIFO: protocol violation.
  - Ignored: no rvalid out, no pointer change.
  - Covered by an assertion.
- Starvation counter:
  - Increment (saturating at MAX_STARVE) on each port-0 grant while m1_req_i=1.
  - Clear on a port-1 grant, or on any cycle with m1_req_i=0.
- Full condition: FIFO full with no rvalid gives instr_req_o=0. No lock is set then, so arbitration can change before the next issue.
- Reset mid-transaction: state clears immediately; late rvalid for pre-reset transactions is dropped as the empty-FIFO case.
- Assertions:
  - Count never exceeds DEPTH.
  - instr_addr_o is stable while instr_req_o & !instr_gnt_i.
  - Never two mX_gnt_o or two mX_rvalid_o high in the same cycle.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle with count=2 -> all outputs 0 asynchronously. After release, an rvalid pulse gives m0_rvalid_o=m1_rvalid_o=0.
- Port 0 only: m0_req_i=1 at 0x100, gnt immediate, rvalid 1 cycle later with rdata 0xDEADBEEF -> m0_gnt_o in cycle 0, m0_rvalid_o with 0xDEADBEEF in cycle 1, m1 outputs quiet.
- Lock: m0 requests 0x200, gnt held low 3 cycles, m1 asserts in cycle 1 -> instr_addr_o stays 0x200 for all 3 cycles; m1 is granted only after m0's grant.
- Starvation, MAX_STARVE=4: m0 and m1 request continuously, gnt always 1 -> grants m0,m0,m0,m0,m1,m0,... Counter returns to 0 after the m1 grant.
- Backpressure, DEPTH=2: two grants with no rvalid -> instr_req_o=0 in the 3rd cycle. rvalid in the 4th cycle -> req re-asserts the same cycle and count stays 2.
- Ordering: issue m0 (0x10), m1 (0x20), then two rvalids with err=0 then err=1 -> first goes to m0 with m0_err_o=0, second to m1 with m1_err_o=1.

Source files
------------

// File: rtl/cv32e40p_instr_obi_arbiter_if.sv
// Signal bundle for the two-requester instruction OBI arbiter.
// slave  : the arbiter's own view (requester inputs, bus responses in).
// master : the surrounding system's view (prefetcher, aux master, memory).
interface cv32e40p_instr_obi_arbiter_if;

    // Port 0: IF-stage fetch requester
    logic        m0_req_i;
    logic [31:0] m0_addr_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic        m0_err_o;

    // Port 1: auxiliary requester (debug program buffer / scrubber)
    logic        m1_req_i;
    logic [31:0] m1_addr_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] m1_rdata_o;
    logic        m1_err_o;

    // Shared instruction bus towards PMP / instruction memory
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;

    // Activity indication
    logic        busy_o;

    modport slave (
        input  m0_req_i, m0_addr_i,
        input  m1_req_i, m1_addr_i,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        output instr_req_o, instr_addr_o,
        output busy_o
    );

    modport master (
        output m0_req_i, m0_addr_i,
        output m1_req_i, m1_addr_i,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        input  instr_req_o, instr_addr_o,
        input  busy_o
    );

endinterface

// File: rtl/cv32e40p_instr_obi_arbiter.sv
// Two-port OBI instruction arbiter.
// Port 0 (fetch) has fixed priority; port 1 (aux) is forced through after
// MAX_STARVE consecutive port-0 grants while it waits. An ungranted request
// locks the selection so address and master stay stable until granted.
// Each granted transaction's port ID is queued in issue order so responses
// are steered back to the requester that issued them.
module cv32e40p_instr_obi_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    cv32e40p_instr_obi_arbiter_if.slave   bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = $clog2(MAX_STARVE + 1);

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(MAX_STARVE);

    if (DEPTH < 1) begin : g_bad_depth
        $error("DEPTH must be at least 1");
    end
    if (MAX_STARVE < 1) begin : g_bad_starve
        $error("MAX_STARVE must be at least 1");
    end

    // ID FIFO: one bit per slot, 0 = port 0, 1 = port 1
    logic [DEPTH-1:0] id_q,    id_d;
    logic [PTR_W-1:0] wptr_q,  wptr_d;
    logic [PTR_W-1:0] rptr_q,  rptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Arbitration state
    logic [STV_W-1:0] starve_q, starve_d;
    logic             lock_q,   lock_d;
    logic             lock_sel_q, lock_sel_d;

    // Datapath / handshake
    logic sel;
    logic req_sel;
    logic issue;
    logic grant;
    logic fifo_empty;
    logic pop;
    logic head;

    // Pick the requester: locked choice first, then priority with starvation guard
    always_comb begin
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (bus.m1_req_i && (!bus.m0_req_i || (starve_q == STARVE_MAX))) begin
            sel = 1'b1;
        end else begin
            sel = 1'b0;
        end
    end

    // Issue gating, grant and response steering
    always_comb begin
        fifo_empty = (cnt_q == '0);
        req_sel    = sel ? bus.m1_req_i : bus.m0_req_i;
        // A response retiring this cycle frees a slot for a same-cycle issue
        issue      = req_sel && ((cnt_q < DEPTH_C) || bus.instr_rvalid_i);
        grant      = issue && bus.instr_gnt_i;
        // A response with nothing outstanding is dropped without effect
        pop        = bus.instr_rvalid_i && !fifo_empty;
        head       = id_q[rptr_q];
    end

    assign bus.instr_req_o  = issue;
    assign bus.instr_addr_o = sel ? bus.m1_addr_i : bus.m0_addr_i;

    assign bus.m0_gnt_o     = grant && !sel;
    assign bus.m1_gnt_o     = grant &&  sel;

    assign bus.m0_rvalid_o  = pop && !head;
    assign bus.m1_rvalid_o  = pop &&  head;
    assign bus.m0_err_o     = pop && !head && bus.instr_err_i;
    assign bus.m1_err_o     = pop &&  head && bus.instr_err_i;
    assign bus.m0_rdata_o   = bus.instr_rdata_i;
    assign bus.m1_rdata_o   = bus.instr_rdata_i;

    assign bus.busy_o       = !fifo_empty || issue;

    // Next state for the ID FIFO, outstanding count, lock and starvation counter
    always_comb begin
        id_d       = id_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        starve_d   = starve_q;

        if (grant) begin
            id_d[wptr_q] = sel;
            wptr_d       = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        end

        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
        end

        unique case ({grant, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Lock follows an ungranted request; it drops as soon as the grant arrives
        lock_d = issue && !bus.instr_gnt_i;
        if (lock_d) begin
            lock_sel_d = sel;
        end

        if (!bus.m1_req_i || (grant && sel)) begin
            starve_d = '0;
        end else if (grant && !sel && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q       <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            starve_q   <= '0;
        end else begin
            id_q       <= id_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            starve_q   <= starve_d;
        end
    end

`ifndef SYNTHESIS
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= DEPTH_C);

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.instr_req_o && !bus.instr_gnt_i) |=> $stable(bus.instr_addr_o));

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.m0_gnt_o && bus.m1_gnt_o));

    a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.m0_rvalid_o && bus.m1_rvalid_o));

    a_orphan_rvalid_dropped: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.instr_rvalid_i && fifo_empty) |-> (!bus.m0_rvalid_o && !bus.m1_rvalid_o));

    c_orphan_rvalid: cover property (@(posedge clk) disable iff (!rst_n)
        bus.instr_rvalid_i && fifo_empty);
`endif

endmodule
